// File: rtl/cba_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-bypass adder.
// The issuing side uses the master modport; the adder uses the slave modport.
interface cba_pipe_adder_if #(
  parameter int WIDTH = 16,
  parameter int NB    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [NB-1:0]    skip_mask;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, skip_mask
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, skip_mask
  );
endinterface

// File: rtl/cba_pipe_adder.sv
// Pipelined carry-bypass adder/subtractor: one BLOCK-bit bypass block per stage,
// operands skewed down the pipe, global stall driven by the result handshake.
module cba_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic            clk,
  input  logic            rst,
  cba_pipe_adder_if.slave bus
);
  localparam int NB = WIDTH / BLOCK;

  generate
    if (((WIDTH % BLOCK) != 0) || (BLOCK < 2)) begin : g_bad_cfg
      $error("cba_pipe_adder: WIDTH must be a multiple of BLOCK and BLOCK must be at least 2");
    end
  endgenerate

  // Level 0 holds the captured operands; level k+1 holds the result of block k.
  logic             valid_r [0:NB];
  logic             carry_r [0:NB];
  logic [WIDTH-1:0] sum_r   [0:NB];
  logic [NB-1:0]    skip_r  [0:NB];
  logic [WIDTH-1:0] a_r     [0:NB-1];
  logic [WIDTH-1:0] b_r     [0:NB-1];
  logic             ovf_r;

  logic [WIDTH-1:0] nxt_sum  [0:NB-1];
  logic [NB-1:0]    nxt_skip [0:NB-1];
  logic             blk_cout [0:NB-1];
  logic             msb_cin;
  logic             advance;

  assign advance      = !valid_r[NB] || bus.out_ready;
  assign bus.in_ready = !rst && advance;

  // Per-block ripple sum, propagate detection and bypass carry selection.
  always_comb begin : p_blocks
    logic c;
    logic p;
    logic x;
    c = 1'b0;
    p = 1'b0;
    x = 1'b0;
    for (int k = 0; k < NB; k++) begin
      c           = carry_r[k];
      p           = 1'b1;
      nxt_sum[k]  = sum_r[k];
      nxt_skip[k] = skip_r[k];
      for (int i = 0; i < BLOCK; i++) begin
        x = a_r[k][k*BLOCK+i] ^ b_r[k][k*BLOCK+i];
        nxt_sum[k][k*BLOCK+i] = x ^ c;
        c = (a_r[k][k*BLOCK+i] & b_r[k][k*BLOCK+i]) | (x & c);
        p = p & x;
      end
      nxt_skip[k][k] = p;
      // When every bit propagates, the ripple result equals the block carry-in anyway.
      blk_cout[k]    = p ? carry_r[k] : c;
    end
  end

  // Carry into the MSB recovered from the final block's sum and operand bits.
  assign msb_cin = nxt_sum[NB-1][WIDTH-1] ^ a_r[NB-1][WIDTH-1] ^ b_r[NB-1][WIDTH-1];

  // Pipeline registers: clear on reset, advance together, or hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= NB; k++) begin
        valid_r[k] <= 1'b0;
        carry_r[k] <= 1'b0;
        sum_r[k]   <= '0;
        skip_r[k]  <= '0;
      end
      for (int k = 0; k < NB; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
      ovf_r <= 1'b0;
    end else if (advance) begin
      valid_r[0] <= bus.in_valid;
      carry_r[0] <= bus.sub ? 1'b1 : bus.cin;
      a_r[0]     <= bus.a;
      b_r[0]     <= bus.sub ? ~bus.b : bus.b;
      sum_r[0]   <= '0;
      skip_r[0]  <= '0;
      for (int k = 0; k < NB; k++) begin
        valid_r[k+1] <= valid_r[k];
        carry_r[k+1] <= blk_cout[k];
        sum_r[k+1]   <= nxt_sum[k];
        skip_r[k+1]  <= nxt_skip[k];
      end
      for (int k = 1; k < NB; k++) begin
        a_r[k] <= a_r[k-1];
        b_r[k] <= b_r[k-1];
      end
      ovf_r <= msb_cin ^ blk_cout[NB-1];
    end
  end

  assign bus.out_valid = valid_r[NB];
  assign bus.sum       = sum_r[NB];
  assign bus.cout      = carry_r[NB];
  assign bus.ovf       = ovf_r;
  assign bus.skip_mask = skip_r[NB];
endmodule

// File: tb/tb_cba_pipe_adder.sv
// Directed and randomised checks of cba_pipe_adder at 16/4 and 32/8.
module tb_cba_pipe_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cba_pipe_adder_if #(.WIDTH(16), .NB(4)) bus16 ();
  cba_pipe_adder_if #(.WIDTH(32), .NB(4)) bus32 ();

  cba_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  cba_pipe_adder #(.WIDTH(32), .BLOCK(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    logic [7:0]  sk;
  } exp_t;
  exp_t q16[$];
  exp_t q32[$];

  // Hand-computed vectors: a, b, cin, sub -> sum, cout, ovf, skip_mask
  logic [15:0] va  [8] = '{16'h7FFF, 16'h1234, 16'h00FF, 16'hFFFF, 16'h0005, 16'h0000, 16'h8000, 16'h7FFF};
  logic [15:0] vb  [8] = '{16'h0001, 16'h4321, 16'h0F00, 16'hFFFF, 16'h0005, 16'h0001, 16'h8000, 16'hFFFF};
  logic        vc  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        vs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] es  [8] = '{16'h8000, 16'h5555, 16'h1000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000};
  logic        eco [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        eov [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0]  esk [8] = '{4'b0110, 4'b0000, 4'b0111, 4'b0000, 4'b1111, 4'b1110, 4'b0000, 4'b0111};

  task automatic model(input int w, input int blk, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic s, output exp_t e);
    logic [63:0] m, bm, bb, full, px;
    m    = (64'h1 << w) - 64'h1;
    bm   = (64'h1 << blk) - 64'h1;
    bb   = (s ? ~b : b) & m;
    full = (a & m) + bb + {63'h0, (s ? 1'b1 : c)};
    e.s  = full & m;
    e.co = full[w];
    e.ov = e.s[w-1] ^ a[w-1] ^ bb[w-1] ^ e.co;
    e.sk = 8'h00;
    px   = (a ^ bb) & m;
    for (int k = 0; k < w / blk; k++) e.sk[k] = (((px >> (k * blk)) & bm) == bm);
  endtask

  task automatic run_beat(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                          output logic [15:0] sum, output logic co, output logic ov,
                          output logic [3:0] sk, output int lat);
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.cin = c; bus16.sub = s;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    #1;
    lat = 0;
    while (!bus16.in_ready && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    sum = bus16.sum; co = bus16.cout; ov = bus16.ovf; sk = bus16.skip_mask;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask} !== 23'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b sum=%h cout=%b ovf=%b skip=%b, want all zero",
               bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask);
    end
    n_tests++;
    if (bus16.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus16.in_ready);
    end
    n_tests++;
    if ({bus32.out_valid, bus32.sum} !== 33'h0) begin
      n_fail++; $display("FAIL reset_w32: got v=%b sum=%h want 0", bus32.out_valid, bus32.sum);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus16.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_in_ready: got %b want 1", bus16.in_ready);
    end
  endtask

  task automatic test_add_wrap();
    logic [15:0] s; logic co, ov; logic [3:0] sk; int lat;
    run_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, sk, lat);
    n_tests++;
    if ({s, co, ov, sk} !== {16'h0000, 1'b1, 1'b0, 4'b1110}) begin
      n_fail++;
      $display("FAIL add_wrap: got sum=%h cout=%b ovf=%b skip=%b want 0000 1 0 1110", s, co, ov, sk);
    end
    n_tests++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL add_wrap_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_sub_ovf();
    logic [15:0] s; logic co, ov; logic [3:0] sk; int lat;
    run_beat(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, sk, lat);
    n_tests++;
    if ({s, co, ov, sk} !== {16'h7FFF, 1'b1, 1'b1, 4'b0110}) begin
      n_fail++;
      $display("FAIL sub_ovf: got sum=%h cout=%b ovf=%b skip=%b want 7fff 1 1 0110", s, co, ov, sk);
    end
    run_beat(16'h0003, 16'h0005, 1'b1, 1'b1, s, co, ov, sk, lat);
    n_tests++;
    if ({s, co, ov, sk} !== {16'hFFFE, 1'b0, 1'b0, 4'b1110}) begin
      n_fail++;
      $display("FAIL sub_borrow: got sum=%h cout=%b ovf=%b skip=%b want fffe 0 0 1110", s, co, ov, sk);
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (bus16.out_valid) begin
        n_tests++;
        if (got >= 8 || cyc != 5 + got) begin
          n_fail++; $display("FAIL b2b_timing: result %0d at cycle %0d want cycle %0d", got, cyc, 5 + got);
        end else if ({bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask} !==
                     {es[got], eco[got], eov[got], esk[got]}) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got sum=%h cout=%b ovf=%b skip=%b want %h %b %b %b", got,
                   bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask, es[got], eco[got], eov[got], esk[got]);
        end
        got++;
      end
      bus16.out_ready = 1'b1;
      if (cyc < 8) begin
        bus16.a = va[cyc]; bus16.b = vb[cyc]; bus16.cin = vc[cyc]; bus16.sub = vs[cyc];
        bus16.in_valid = 1'b1;
        #1;
        n_tests++;
        if (bus16.in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", cyc, bus16.in_ready);
        end
      end else begin
        bus16.in_valid = 1'b0;
      end
    end
    n_tests++;
    if (got != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 8", got);
    end
  endtask

  task automatic test_backpressure();
    logic [22:0] snap;
    int n = 0;
    int got = 0;
    bus16.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus16.a = va[i]; bus16.b = vb[i]; bus16.cin = vc[i]; bus16.sub = vs[i];
      bus16.in_valid = 1'b1;
    end
    @(negedge clk);
    bus16.in_valid = 1'b0;
    while (!bus16.out_valid && n < 20) begin
      @(negedge clk); n++;
    end
    snap = {bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask};
    bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.sub = 1'b0; bus16.cin = 1'b1;
    bus16.in_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_tests++;
      if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1 ||
          {bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask} !== snap) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got in_ready=%b out_valid=%b out=%h want 0 1 %h", s,
                 bus16.in_ready, bus16.out_valid, {bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask}, snap);
      end
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus16.out_valid && bus16.out_ready) begin
        n_tests++;
        if (got >= 4 || {bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask} !==
                        {es[got+1], eco[got+1], eov[got+1], esk[got+1]}) begin
          n_fail++;
          $display("FAIL bp_result%0d: got sum=%h cout=%b ovf=%b skip=%b", got,
                   bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask);
        end
        got++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (got != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d results want 4", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic co, ov; logic [3:0] sk; int lat;
    int stale = 0;
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus16.a = va[i]; bus16.b = vb[i]; bus16.cin = vc[i]; bus16.sub = vs[i];
      bus16.in_valid = 1'b1;
    end
    @(negedge clk);
    bus16.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus16.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_in_ready: got %b want 0", bus16.in_ready);
    end
    @(negedge clk);
    n_tests++;
    if ({bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask} !== 23'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got v=%b sum=%h cout=%b ovf=%b skip=%b want all zero",
               bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus16.out_valid) stale++;
    end
    n_tests++;
    if (stale != 0) begin
      n_fail++; $display("FAIL midrst_stale: got %0d stale results want 0", stale);
    end
    run_beat(16'h1234, 16'h4321, 1'b0, 1'b0, s, co, ov, sk, lat);
    n_tests++;
    if ({s, co, ov, sk} !== {16'h5555, 1'b0, 1'b0, 4'b0000} || lat !== 4) begin
      n_fail++;
      $display("FAIL midrst_next: got sum=%h cout=%b ovf=%b skip=%b lat=%0d want 5555 0 0 0000 4",
               s, co, ov, sk, lat);
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int cyc = 0; cyc < 10010; cyc++) begin
      @(negedge clk);
      bus16.in_valid  = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus16.out_ready = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus16.a = 16'($urandom); bus16.b = 16'($urandom);
      bus16.cin = 1'($urandom); bus16.sub = 1'($urandom);
      bus32.in_valid  = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus32.out_ready = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus32.a = $urandom; bus32.b = $urandom;
      bus32.cin = 1'($urandom); bus32.sub = 1'($urandom);
      #1;
      if (bus16.in_valid && bus16.in_ready) begin
        model(16, 4, {48'h0, bus16.a}, {48'h0, bus16.b}, bus16.cin, bus16.sub, e);
        q16.push_back(e);
      end
      if (bus32.in_valid && bus32.in_ready) begin
        model(32, 8, {32'h0, bus32.a}, {32'h0, bus32.b}, bus32.cin, bus32.sub, e);
        q32.push_back(e);
      end
      if (bus16.out_valid && bus16.out_ready) begin
        n_tests++;
        if (q16.size() == 0) begin
          n_fail++; $display("FAIL rand16_extra: unexpected result sum=%h", bus16.sum);
        end else begin
          e = q16.pop_front();
          if ({bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask} !== {e.s[15:0], e.co, e.ov, e.sk[3:0]}) begin
            n_fail++;
            $display("FAIL rand16: got sum=%h cout=%b ovf=%b skip=%b want %h %b %b %b",
                     bus16.sum, bus16.cout, bus16.ovf, bus16.skip_mask, e.s[15:0], e.co, e.ov, e.sk[3:0]);
          end
        end
      end
      if (bus32.out_valid && bus32.out_ready) begin
        n_tests++;
        if (q32.size() == 0) begin
          n_fail++; $display("FAIL rand32_extra: unexpected result sum=%h", bus32.sum);
        end else begin
          e = q32.pop_front();
          if ({bus32.sum, bus32.cout, bus32.ovf, bus32.skip_mask} !== {e.s[31:0], e.co, e.ov, e.sk[3:0]}) begin
            n_fail++;
            $display("FAIL rand32: got sum=%h cout=%b ovf=%b skip=%b want %h %b %b %b",
                     bus32.sum, bus32.cout, bus32.ovf, bus32.skip_mask, e.s[31:0], e.co, e.ov, e.sk[3:0]);
          end
        end
      end
    end
    n_tests++;
    if (q16.size() != 0 || q32.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: got %0d/%0d pending want 0/0", q16.size(), q32.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
    bus16.a = 16'h0; bus16.b = 16'h0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    bus32.a = 32'h0; bus32.b = 32'h0; bus32.cin = 1'b0; bus32.sub = 1'b0;
    test_reset();
    test_add_wrap();
    test_sub_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
